// File: rtl/bin2bcd_display_fmt_if.sv
// Bundle between the counter/display side and the BCD formatter.
// master drives the binary value and load request; slave returns the formatted result.
interface bin2bcd_display_fmt_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic [WIDTH-1:0]    value_in;
  logic                load;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   digit_en;
  logic                busy;
  logic                done;

  modport master (
    output value_in,
    output load,
    input  bcd_out,
    input  digit_en,
    input  busy,
    input  done
  );

  modport slave (
    input  value_in,
    input  load,
    output bcd_out,
    output digit_en,
    output busy,
    output done
  );
endinterface

// File: rtl/bin2bcd_display_fmt.sv
// Sequential double-dabble (one bit per clock) binary-to-BCD converter with leading-zero mask.
// The published result only changes on completion, so the display never sees a partial value.
module bin2bcd_display_fmt #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit AUTO   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  bin2bcd_display_fmt_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic              r_pending;
  logic [WIDTH-1:0]  r_last_val;
  logic [WIDTH-1:0]  r_shreg;
  logic [BW-1:0]     r_scratch;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bcd;
  logic [DIGITS-1:0] r_digit_en;
  logic              r_busy;
  logic              r_done;

  logic              w_start;
  logic              w_latch;
  logic              w_shift;
  logic              w_finish;
  logic              w_set_pend;
  logic              w_clr_pend;
  logic [BW-1:0]     w_scr_adj;
  logic [BW-1:0]     w_scr_nx;

  function automatic logic [BW-1:0] f_dabble_adjust(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  // A digit is shown when it or any more significant digit is nonzero; digit0 always shows.
  function automatic logic [DIGITS-1:0] f_digit_en(input logic [BW-1:0] s);
    logic              seen;
    logic [DIGITS-1:0] e;
    seen = 1'b0;
    e    = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen | (s[4*i +: 4] != 4'd0);
      e[i] = seen;
    end
    e[0] = 1'b1;
    return e;
  endfunction

  assign w_start   = bus.load | (AUTO & (bus.value_in != r_last_val));
  assign w_scr_adj = f_dabble_adjust(r_scratch);
  assign w_scr_nx  = {w_scr_adj[BW-2:0], r_shreg[WIDTH-1]};

  // Next-state and control decode.
  always_comb begin
    w_state_nx = r_state;
    w_latch    = 1'b0;
    w_shift    = 1'b0;
    w_finish   = 1'b0;
    w_set_pend = 1'b0;
    w_clr_pend = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_latch    = 1'b1;
          w_state_nx = SHIFT;
        end else begin
          w_state_nx = IDLE;
        end
      end
      SHIFT: begin
        w_shift    = 1'b1;
        w_set_pend = bus.load;
        if (r_cnt == CNT_LAST) begin
          w_finish   = 1'b1;
          w_state_nx = DONE;
        end else begin
          w_state_nx = SHIFT;
        end
      end
      DONE: begin
        w_clr_pend = 1'b1;
        if (r_pending | w_start) begin
          w_latch    = 1'b1;
          w_state_nx = SHIFT;
        end else begin
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Shift datapath, request latching and pending-request tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending  <= 1'b0;
      r_last_val <= {WIDTH{1'b0}};
      r_shreg    <= {WIDTH{1'b0}};
      r_scratch  <= {BW{1'b0}};
      r_cnt      <= {CW{1'b0}};
    end else begin
      if (w_latch) begin
        r_shreg    <= bus.value_in;
        r_last_val <= bus.value_in;
        r_scratch  <= {BW{1'b0}};
        r_cnt      <= {CW{1'b0}};
      end else if (w_shift) begin
        r_shreg    <= {r_shreg[WIDTH-2:0], 1'b0};
        r_scratch  <= w_scr_nx;
        r_cnt      <= r_cnt + CNT_ONE;
      end
      if (w_set_pend) begin
        r_pending <= 1'b1;
      end else if (w_clr_pend) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Published outputs: result is written only by the final shift edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd      <= {BW{1'b0}};
      r_digit_en <= {{(DIGITS-1){1'b0}}, 1'b1};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy <= (w_state_nx == SHIFT);
      r_done <= (w_state_nx == DONE);
      if (w_finish) begin
        r_bcd      <= w_scr_nx;
        r_digit_en <= f_digit_en(w_scr_nx);
      end
    end
  end

  assign bus.bcd_out  = r_bcd;
  assign bus.digit_en = r_digit_en;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_bin2bcd_display_fmt.sv
// Bench for bin2bcd_display_fmt: one AUTO=0 and one AUTO=1 instance, checked every cycle
// against a timeline model using decimal arithmetic, plus directed literal expectations.
module tb_bin2bcd_display_fmt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] vin  [2];
  logic        load [2];

  int errors = 0;
  int checks = 0;
  int dcount [2];

  bin2bcd_display_fmt_if #(.WIDTH(16), .DIGITS(5)) if0 ();
  bin2bcd_display_fmt_if #(.WIDTH(16), .DIGITS(5)) if1 ();

  bin2bcd_display_fmt #(.WIDTH(16), .DIGITS(5), .AUTO(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  bin2bcd_display_fmt #(.WIDTH(16), .DIGITS(5), .AUTO(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if0.value_in = vin[0];
  assign if0.load     = load[0];
  assign if1.value_in = vin[1];
  assign if1.load     = load[1];

  logic        o_busy [2];
  logic        o_done [2];
  logic [19:0] o_bcd  [2];
  logic [4:0]  o_den  [2];
  assign o_busy[0] = if0.busy;     assign o_busy[1] = if1.busy;
  assign o_done[0] = if0.done;     assign o_done[1] = if1.done;
  assign o_bcd[0]  = if0.bcd_out;  assign o_bcd[1]  = if1.bcd_out;
  assign o_den[0]  = if0.digit_en; assign o_den[1]  = if1.digit_en;

  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    r = 20'h00000;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] shown_mask(input int v);
    logic [4:0] e;
    int p;
    e = 5'b00001;
    p = 10;
    for (int i = 1; i < 5; i++) begin
      if (v >= p) e[i] = 1'b1;
      p = p * 10;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a request occupies 16 clocks, then one result cycle; loads while busy collapse.
  int  m_remain [2] = '{0, 0};
  bit  m_done   [2] = '{1'b0, 1'b0};
  bit  m_pend   [2] = '{1'b0, 1'b0};
  int  m_val    [2] = '{0, 0};
  int  m_last   [2] = '{0, 0};
  int  m_shown  [2] = '{0, 0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_remain[k] = 0; m_done[k] = 1'b0; m_pend[k] = 1'b0;
        m_val[k] = 0; m_last[k] = 0; m_shown[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit start;
        start = load[k] || (k == 1 && int'(vin[k]) != m_last[k]);
        if (m_done[k]) begin
          m_done[k] = 1'b0;
          if (m_pend[k] || start) begin
            m_val[k] = int'(vin[k]); m_last[k] = int'(vin[k]); m_remain[k] = 16;
          end
          m_pend[k] = 1'b0;
        end else if (m_remain[k] > 0) begin
          if (load[k]) m_pend[k] = 1'b1;
          m_remain[k] = m_remain[k] - 1;
          if (m_remain[k] == 0) begin
            m_shown[k] = m_val[k];
            m_done[k]  = 1'b1;
          end
        end else if (start) begin
          m_val[k] = int'(vin[k]); m_last[k] = int'(vin[k]); m_remain[k] = 16;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(m_remain[k] > 0));
      chk($sformatf("done%0d", k), 32'(o_done[k]), 32'(m_done[k]));
      chk($sformatf("bcd%0d", k),  32'(o_bcd[k]),  32'(to_bcd(m_shown[k])));
      chk($sformatf("den%0d", k),  32'(o_den[k]),  32'(shown_mask(m_shown[k])));
      if (o_done[k] === 1'b1) dcount[k]++;
    end
  end

  task automatic start0(input logic [15:0] v);
    vin[0]  = v;
    load[0] = 1'b1;
    @(posedge clk);
    #1 load[0] = 1'b0;
  endtask

  // Counts negedges until done is seen; also counts busy negedges along the way.
  task automatic wait_done(input int k, output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (o_busy[k] === 1'b1) nbusy++;
      if (o_done[k] === 1'b1) break;
      if (n > 60) begin
        chk($sformatf("timeout%0d", k), 32'd0, 32'd1);
        break;
      end
    end
  endtask

  int n, nb, snap0, snap1;

  initial begin
    dcount[0] = 0; dcount[1] = 0;
    vin[0] = 16'd1234; vin[1] = 16'd1234;
    load[0] = 1'b1; load[1] = 1'b1;
    #1 rst = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_bcd0", 32'(o_bcd[0]), 32'h00000);
      chk("rst_den0", 32'(o_den[0]), 32'b00001);
      chk("rst_busy0", 32'(o_busy[0]), 32'd0);
      chk("rst_done1", 32'(o_done[1]), 32'd0);
    end
    @(posedge clk); #1;
    load[0] = 1'b0; load[1] = 1'b0; vin[1] = 16'd0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    start0(16'd1234);
    wait_done(0, n, nb);
    chk("lat1234", 32'(n - 1), 32'd16);
    chk("busy1234", 32'(nb), 32'd16);
    chk("bcd1234", 32'(o_bcd[0]), 32'h01234);
    chk("den1234", 32'(o_den[0]), 32'b01111);
    repeat (3) @(posedge clk);
    #1;

    start0(16'hFFFF);
    wait_done(0, n, nb);
    chk("bcdFFFF", 32'(o_bcd[0]), 32'h65535);
    chk("denFFFF", 32'(o_den[0]), 32'b11111);
    @(posedge clk); #1;
    start0(16'd0);
    wait_done(0, n, nb);
    chk("bcd0", 32'(o_bcd[0]), 32'h00000);
    chk("den0", 32'(o_den[0]), 32'b00001);
    repeat (3) @(posedge clk);
    #1;

    snap0 = dcount[0];
    start0(16'd1234);
    repeat (5) @(posedge clk);
    #1;
    vin[0] = 16'd42; load[0] = 1'b1;
    @(posedge clk); #1 load[0] = 1'b0;
    wait_done(0, n, nb);
    chk("pend_first", 32'(o_bcd[0]), 32'h01234);
    wait_done(0, n, nb);
    chk("pend_gap", 32'(n), 32'd17);
    chk("pend_bcd", 32'(o_bcd[0]), 32'h00042);
    chk("pend_den", 32'(o_den[0]), 32'b00011);
    repeat (30) @(posedge clk);
    chk("pend_count", 32'(dcount[0] - snap0), 32'd2);
    #1;

    snap0 = dcount[0];
    start0(16'd9999);
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_bcd", 32'(o_bcd[0]), 32'h00000);
    chk("mid_rst_den", 32'(o_den[0]), 32'b00001);
    chk("mid_rst_busy", 32'(o_busy[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (25) @(posedge clk);
    chk("mid_rst_nodone", 32'(dcount[0] - snap0), 32'd0);
    #1;
    start0(16'd7);
    wait_done(0, n, nb);
    chk("after_rst_bcd", 32'(o_bcd[0]), 32'h00007);
    chk("after_rst_den", 32'(o_den[0]), 32'b00001);
    repeat (3) @(posedge clk);
    #1;

    snap1 = dcount[1];
    vin[1] = 16'd7;
    wait_done(1, n, nb);
    chk("auto_lat", 32'(n - 1), 32'd17);
    chk("auto_bcd", 32'(o_bcd[1]), 32'h00007);
    chk("auto_den", 32'(o_den[1]), 32'b00001);
    repeat (40) @(posedge clk);
    chk("auto_once", 32'(dcount[1] - snap1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_display_fmt.md
Name: bin2bcd_display_fmt

Overview:
- Sits between keyin_counter and display.
- Converts the 16-bit binary value_out from keyin_counter into packed 5-digit BCD, using a sequential double-dabble shifter with one bit per clock.
- Also produces a leading-zero blanking mask, so display drives only the significant digits.
- Holds the last result stable while a new conversion runs, so display never sees a partial value.

Parameters:
WIDTH, 16, binary input width
DIGITS, 5, BCD output digits (4 bits each); must satisfy 10^DIGITS > 2^WIDTH-1
AUTO, 1, 1 = start a conversion automatically when value_in changes; 0 = convert only on load

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
value_in  input  WIDTH  binary value from keyin_counter
load  input  1  one-cycle request to convert value_in
bcd_out  output  4*DIGITS  packed BCD; digit0 = [3:0], least significant
digit_en  output  DIGITS  1 = digit is significant and shown
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when bcd_out/digit_en are updated

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: bcd_out=0, digit_en=1 (only digit0 shown), busy=0, done=0.
  - Internal: state=IDLE, pending=0, last_val=0, bit counter=0, scratch=0.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE:
  - A start condition is load=1, or (AUTO=1 and value_in != last_val).
  - On a start condition: latch value_in into the shift register and into last_val, clear the BCD scratch, set counter=0, go to SHIFT.
- SHIFT, one bit per clock:
  - First, each scratch digit >=5 gets +3.
  - Then {scratch, shreg} shifts left by 1.
  - Counter increments.
  - On the WIDTH-th shift, the same edge writes bcd_out and digit_en from the final scratch and goes to DONE.
- DONE: lasts one cycle.
  - done=1 during this cycle.
  - If pending=1, or a start condition is true now: clear pending, relatch value_in/last_val, go to SHIFT.
  - Otherwise go to IDLE.
- busy=1 exactly while in SHIFT; busy=0 in IDLE and DONE.
- Latency: done is high in the cycle following the WIDTH-th edge after the edge that sampled load. With WIDTH=16, that is 16 cycles.
- Load during SHIFT:
  - Sets pending and does not abort the conversion in progress.
  - Multiple loads collapse into one pending request.
  - The restarted conversion uses value_in as sampled in DONE (the latest value), not the value present when load arrived.
- With AUTO=1, a value_in change during SHIFT is detected in DONE or IDLE through last_val, so no change is ever lost.
- bcd_out/digit_en change only on the edge that enters DONE; they are never partial.
- digit_en rule:
  - digit_en[i]=1 if any digit j>=i is nonzero.
  - digit_en[0] is always 1.
  - Value 0 gives digit_en=1 (only digit0 shown).
- No overflow case exists: the maximum 16-bit value 65535 fits in 5 digits.
- Reset asserted mid-conversion: immediate return to the reset values, no done pulse, pending cleared.
- A load coincident with reset release is ignored; the first edge with rst=1 may sample load.

Test Plan:
- Reset: hold rst=0 with load=1 and value_in=1234 -> bcd_out=20'h00000, digit_en=5'b00001, busy=0, done=0 throughout.
- AUTO=0, load pulse with value_in=16'd1234 -> busy high for 16 cycles; done high exactly 16 cycles after the sampling edge; bcd_out=20'h01234, digit_en=5'b01111.
- AUTO=0, value_in=16'hFFFF, load -> bcd_out=20'h65535, digit_en=5'b11111. Then value_in=0, load -> bcd_out=20'h00000, digit_en=5'b00001.
- Load of 1234, then load of value_in=42 at shift cycle 5 -> first done with 20'h01234; second conversion starts from DONE with no IDLE cycle; second done 17 cycles after the first with 20'h00042, digit_en=5'b00011; exactly two done pulses.
- Load of 9999, rst pulsed low at shift cycle 8 -> outputs at reset values, no done ever; after release, a new load of 7 gives 20'h00007, digit_en=5'b00001.
- AUTO=1, no load, value_in steps 0->7 and is then held -> one conversion, done once, bcd_out=20'h00007; no further done while value_in is stable.
